display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexing scheduler for the eight-digit seven-segment display of the tail-light board. It takes a frame of eight 4-bit digit codes plus an enable mask, latches it into a shadow register on a load request, and applies it only at a frame boundary so a frame never shows mixed data. It scans the digits with a blanking gap between slots to prevent ghosting, with optional PWM brightness. It sits between the light-to-segment mapping and the board pins AN/CA..CG.

## Interface
- DIGIT_CYCLES, 100000: ON-phase length per digit slot in clk cycles; must be a multiple of 16, ≥16.
- BLANK_CYCLES, 1000: blank gap before each ON phase; ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_in  in  32  digit codes; bits [4k+3:4k] belong to digit k.
- en_in  in  8  digit enable mask; bit k=1 lights digit k.
- load  in  1  single-cycle request to capture frame_in/en_in into the pending register.
- brightness  in  4  duty level; ON time = (brightness+1)/16 of the ON phase.
- AN  out  8  active-low anodes; bit k selects digit k.
- SEG  out  7  active-low cathodes {CA,CB,CC,CD,CE,CF,CG}.
- frame_done  out  1  one-cycle pulse on the last cycle of digit 7's slot.

## Operation
- Per-slot FSM with states BLANK and ON. The slot index `idx` is 3 bits and runs 0..7, wrapping 7→0.
- BLANK: hold for BLANK_CYCLES cycles with AN=8'hFF and SEG=7'h7F, then go to ON.
- ON: hold for DIGIT_CYCLES cycles, then go to BLANK with idx+1.
- The frame boundary is the last ON cycle of idx=7.
- During ON:
  - If active_en[idx]=1 and the PWM gate is open: AN = ~(8'b1 << idx), and SEG = decode(active_code[idx]).
  - Otherwise AN=8'hFF and SEG=7'h7F.
  - Disabled digits still consume their full slot, so the refresh rate is constant.
- Decode: standard hex 0–F glyphs, active-low.
- Load handling:
  - load copies frame_in/en_in into the pending register and sets pend=1.
  - A second load before the boundary overwrites the pending data; the last load wins.
- Frame boundary:
  - If pend=1, copy pending into active and clear pend.
  - If load is asserted on the boundary cycle itself, that cycle's frame_in/en_in go directly to active and pend ends at 0.
- PWM gate: within ON, sub = ON-cycle count / (DIGIT_CYCLES/16), range 0..15. The gate is open when sub ≤ brightness.
- Width rules: cycle counters are sized by $clog2(max(DIGIT_CYCLES, BLANK_CYCLES)), with no overflow. brightness=15 gives 100% of the ON phase; brightness=0 gives 1/16.

## Timing
- Reset values:
  - AN=8'hFF, SEG=7'h7F, frame_done=0.
  - State BLANK, idx=0, counters 0.
  - active_code=0, active_en=8'h00 (display dark until the first applied load), pend=0.
- Reset asserted mid-scan forces all of the above immediately, asynchronously. Scanning restarts at slot 0 BLANK on the first clk edge after release.
- AN/SEG/frame_done are registered and reflect the state from the previous edge. AN goes low on the first ON cycle of an enabled slot.
- Slot period = BLANK_CYCLES + DIGIT_CYCLES cycles. Frame period = 8 × slot period.
- Latency from load to visible: at most one frame period plus one slot. The new data appears starting with slot 0 of the next frame.
- brightness is sampled every cycle, with no synchronisation; the caller holds it static.

## Configuration
- BRIGHTNESS_PWM_EN defined: PWM gating as described above.
- BRIGHTNESS_PWM_EN undefined: the brightness port is ignored and the gate is always open (full ON phase). The sub-phase counter logic is not generated.

## Structure
- Shared package display_pkg:
  - N_DIGITS=8.
  - Digit-code and segment typedefs: logic [3:0], logic [6:0].
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF constants.
  - Scan-state enum {BLANK, ON}.
- One sub-module: seg7_hex_decode, a combinational 4-bit code → 7-bit active-low segment pattern.

## Test plan
Run with DIGIT_CYCLES=16, BLANK_CYCLES=2 unless noted.
- Reset, no load → AN=8'hFF and SEG=7'h7F for the entire first frame (144 cycles). frame_done pulses at cycle 144 after reset release.
- Load frame_in=32'h76543210, en_in=8'hFF → next frame shows each digit k for 16 cycles after a 2-cycle blank.
  - AN walks 8'hFE..8'h7F.
  - SEG for digit 0 = 7'h01 (glyph 0); digit 1 = 7'h4F.
- en_in=8'h05 → only AN bits 0 and 2 ever go low. frame_done still pulses every 144 cycles.
- Two loads mid-frame (32'h11111111, then 32'h22222222) → next frame shows only 2s. A load asserted on the boundary cycle shows in the very next slot 0.
- With BRIGHTNESS_PWM_EN: brightness=3 → AN low for exactly 4 of 16 ON cycles per enabled slot. brightness=15 → 16 of 16. brightness=0 → 1 of 16.
- Assert reset during ON of slot 5 → AN=8'hFF the same cycle. After release, scanning resumes at slot 0 with a dark display until the next load.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: N_DIGITS, digit_t (4-bit code), seg_t (7-bit active-low {CA..CG}),
//           SEG_BLANK / AN_OFF dark patterns, scan_state_t {BLANK, ON}.
package display_pkg;

   localparam int N_DIGITS = 8;

   typedef logic [3:0] digit_t;
   typedef logic [6:0] seg_t;

   localparam seg_t       SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle of frame/load inputs and display pin outputs of the scan controller.
// Latency: n/a (wires only).
// Backpressure: none; load is a single-cycle request that is always accepted.
// Ports: frame_in[32], en_in[8], load, brightness[4] toward the controller;
//        AN[8], SEG[7], frame_done back from it.
interface display_scan_ctrl_if;
   import display_pkg::*;

   logic [31:0] frame_in;
   logic [7:0]  en_in;
   logic        load;
   logic [3:0]  brightness;
   logic [7:0]  AN;
   seg_t        SEG;
   logic        frame_done;

   modport master (
      output frame_in, en_in, load, brightness,
      input  AN, SEG, frame_done
   );

   modport slave (
      input  frame_in, en_in, load, brightness,
      output AN, SEG, frame_done
   );

endinterface

// File: rtl/display_scan_ctrl_seg7_hex_decode.sv
// Hex digit code to active-low seven-segment pattern {CA,CB,CC,CD,CE,CF,CG}.
// Latency: combinational.
// Backpressure: none.
// Ports: code (4-bit digit code) in, seg (7-bit active-low segments) out.
module seg7_hex_decode
   import display_pkg::*;
(
   input  digit_t code,
   output seg_t   seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'h0: seg = 7'h01;
         4'h1: seg = 7'h4F;
         4'h2: seg = 7'h12;
         4'h3: seg = 7'h06;
         4'h4: seg = 7'h4C;
         4'h5: seg = 7'h24;
         4'h6: seg = 7'h20;
         4'h7: seg = 7'h0F;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h04;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h60;
         4'hC: seg = 7'h31;
         4'hD: seg = 7'h42;
         4'hE: seg = 7'h30;
         4'hF: seg = 7'h38;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scanner: BLANK gap then ON phase per slot, frame-synchronous data swap.
// Latency: outputs registered, aligned with the slot state; a load shows from slot 0 of the next frame.
// Backpressure: none; load always accepted, last load before the frame boundary wins.
// Ports: clk, reset (async, active-high), bus (display_scan_ctrl_if.slave).
// Option: BRIGHTNESS_PWM_EN enables the brightness sub-phase gate; otherwise the full ON phase is lit.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
)(
   input  logic                 clk,
   input  logic                 reset,
   display_scan_ctrl_if.slave   bus
);

   localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CW      = $clog2(MAX_CYC);
   localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   scan_state_t   state, state_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          boundary;

   logic [31:0]   pend_frame, act_frame;
   logic [7:0]    pend_en, act_en;
   logic          pend;

   logic          gate_nxt;
   logic          lit_nxt;
   digit_t        code_nxt;
   seg_t          seg_dec;

   logic [7:0]    an_q;
   seg_t          seg_q;
   logic          fd_q;

   // ---------------- slot FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BLANK;
         idx   <= 3'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + 1'b1;
      boundary  = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_nxt = ON;
               cnt_nxt   = '0;
            end
         end
         ON: begin
            if (cnt == DIGIT_LAST) begin
               state_nxt = BLANK;
               cnt_nxt   = '0;
               idx_nxt   = idx + 3'd1;
               boundary  = (idx == 3'd7);
            end
         end
         default: state_nxt = BLANK;
      endcase
   end

   // ---------------- brightness gate ----------------
`ifdef BRIGHTNESS_PWM_EN
   localparam int SUB_LEN = DIGIT_CYCLES / 16;
   localparam int DW      = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SUB_LEN - 1);

   logic [DW-1:0] sub_div, sub_div_nxt;
   logic [3:0]    sub, sub_nxt;

   // sub tracks which sixteenth of the ON phase the next cycle falls in;
   // it restarts at 0 on every entry into ON.
   always_comb begin
      sub_div_nxt = '0;
      sub_nxt     = 4'd0;
      if (state == ON && state_nxt == ON) begin
         if (sub_div == DIV_LAST) begin
            sub_nxt = sub + 4'd1;
         end else begin
            sub_div_nxt = sub_div + 1'b1;
            sub_nxt     = sub;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sub_div <= '0;
         sub     <= 4'd0;
      end else begin
         sub_div <= sub_div_nxt;
         sub     <= sub_nxt;
      end
   end

   assign gate_nxt = (sub_nxt <= bus.brightness);
`else
   logic unused_brightness;
   assign unused_brightness = ^bus.brightness;
   assign gate_nxt          = 1'b1;
`endif

   // ---------------- pending / active frame ----------------
   // A load on the boundary cycle bypasses pending so it shows in the very next slot 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_frame <= '0;
         pend_en    <= '0;
         pend       <= 1'b0;
         act_frame  <= '0;
         act_en     <= '0;
      end else if (boundary) begin
         pend <= 1'b0;
         if (bus.load) begin
            act_frame <= bus.frame_in;
            act_en    <= bus.en_in;
         end else if (pend) begin
            act_frame <= pend_frame;
            act_en    <= pend_en;
         end
      end else if (bus.load) begin
         pend_frame <= bus.frame_in;
         pend_en    <= bus.en_in;
         pend       <= 1'b1;
      end
   end

   // ---------------- registered pin drive ----------------
   // Outputs are computed from the next-state values so AN/SEG line up with
   // the registered state; the active frame only changes while slot 0 is blank.
   assign code_nxt = act_frame[{idx_nxt, 2'b00} +: 4];
   assign lit_nxt  = (state_nxt == ON) && act_en[idx_nxt] && gate_nxt;

   seg7_hex_decode u_dec (
      .code (code_nxt),
      .seg  (seg_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
         fd_q  <= 1'b0;
      end else begin
         an_q  <= lit_nxt ? ~(8'b1 << idx_nxt) : AN_OFF;
         seg_q <= lit_nxt ? seg_dec : SEG_BLANK;
         fd_q  <= (state_nxt == ON) && (idx_nxt == 3'd7) && (cnt_nxt == DIGIT_LAST);
      end
   end

   assign bus.AN         = an_q;
   assign bus.SEG        = seg_q;
   assign bus.frame_done = fd_q;

endmodule
